rvx10_encoder: RTL and testbench
================================

# rvx10_encoder

Instruction encoder and program-loader for the RVX10 core, the inverse of the ALU control decode path. It accepts a stream of operation requests (4-bit ALU control code plus register fields) over a valid/ready handshake. Each request becomes a 32-bit RV32 R-type or RVX10 custom-0 instruction word, written sequentially into instruction memory through its write port. A session ends with an appended halt word (`beq x0,x0,0`). The block sits beside the core as a self-test and program-generation front end.

## Interface
- `IMEM_AW`, 6, instruction-memory word-address width; capacity 2^IMEM_AW words.
- `BASE_ADDR`, 0, first word address written in each session (IMEM_AW bits).
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  begin a session; sampled only in IDLE or DONE.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  block accepts request this cycle.
- `req_op`  input  4  ALU control code (same encoding as ALUControl).
- `req_rd`, `req_rs1`, `req_rs2`  input  5 each  register indices.
- `req_last`  input  1  final request of session.
- `imem_we`  output  1  instruction-memory write strobe.
- `imem_addr`  output  IMEM_AW  word address.
- `imem_wdata`  output  32  instruction word.
- `busy`  output  1  state is RUN or TERM.
- `done`  output  1  session complete; held until `start` or `reset`.
- `err_illegal`  output  1  sticky: an undefined op code was received.
- `err_overflow`  output  1  sticky: memory filled before `req_last`.
- `count`  output  IMEM_AW+1  words written this session, halt included.

## Operation
- FSM states: IDLE, RUN, TERM, DONE.
  - IDLE/DONE, `start`=1: go to RUN; write pointer = BASE_ADDR; count = 0; errors and `done` cleared.
  - RUN: `req_ready` = (ptr != 2^IMEM_AW−1). The last slot is reserved for the halt word.
  - RUN, accept with `req_last`=1: go to TERM.
  - RUN, ptr reaches the last slot without `req_last`: set `err_overflow`; go to TERM.
  - TERM: write halt word 0x00000063 at ptr; go to DONE.
  - `start` in RUN or TERM is ignored.
- Encode mapping:
  - R-type (opcode 0110011, funct7 0000000 unless noted):
    - 0000 add: f3 000.
    - 0001 sub: f3 000, funct7 0100000.
    - 0101 slt: f3 010.
    - 0011 or: f3 110.
    - 0010 and: f3 111.
  - RVX10 (opcode 0001011, funct7 = {00000, f7_2b}):
    - f7_2b 00: andn 0110 / f3 000; orn 0111 / 001; xorn 1000 / 010.
    - f7_2b 01: min 1001 / 000; max 1010 / 001; minu 1011 / 010; maxu 1100 / 011.
    - f7_2b 10: rol 1101 / 000; ror 1110 / 001.
    - f7_2b 11: abs 1111 / 000; rs2 field forced to 0.
- Illegal code (0100):
  - The request is accepted (handshake completes); no write; ptr and count unchanged.
  - `err_illegal` set.
  - If `req_last` is also set, the block still goes to TERM.
- Each legal accept: ptr += 1; count += 1. The halt write also adds 1 to count.
- Reset (any state, mid-session included): state IDLE, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, ptr = BASE_ADDR, count = 0, `done`/`busy`/errors/`req_ready` = 0.

## Timing
- `imem_we`/`imem_addr`/`imem_wdata` are registered. A request accepted at edge N is written during cycle N→N+1.
- Throughput: one word per cycle with `req_valid` held high.
- `req_last` accepted at edge N: halt word written during N+1→N+2; `done`=1 and `busy`=0 from edge N+2.
- `req_ready` is combinational from state/ptr only, never from `req_valid`.
- `imem_we` is low in IDLE and DONE, and in any cycle following a non-accepting or illegal cycle.

## Structure
- `rvx10_pkg`:
  - ALU control code constants (ALU_ADD … ALU_ABS).
  - OPC_RTYPE = 7'b0110011, OPC_RVX10 = 7'b0001011, HALT_WORD = 32'h00000063.
  - FSM state enum.
- Sub-module `rvx10_instr_pack`: purely combinational (op, rd, rs1, rs2) → {word, illegal}. The top level holds the FSM, pointer, count and output registers.

## Test plan
- Basic encode: start; add x3,x1,x2 (last) → write 0x002081B3 at 0, then 0x00000063 at 1; count=2; `done` at N+2.
- Back-to-back stream: sub x3,x1,x2; min x5,x6,x7; rol x1,x2,x3 (last) → 0x402081B3, 0x0273028B, 0x0431008B on consecutive cycles, then halt at 3.
- abs rs2 masking: abs x10,x11 with rs2=9 → 0x0605850B.
- Illegal op: op 0100 between two adds → `err_illegal`=1; only 3 writes including halt; addresses contiguous.
- Overflow: IMEM_AW=2, five requests without last →
  - words at 0..2;
  - `req_ready` drops when ptr=3;
  - `err_overflow`=1; halt at 3; count=4.
- Reset mid-session after 2 writes → next cycle `imem_we`=0, `busy`=0, count=0. A new start writes from BASE_ADDR again.

Source files
------------

// File: rtl/rvx10_pkg.sv
// Shared constants for the RVX10 instruction encoder: ALU control codes,
// major opcodes, the halt word and the loader FSM state type.
package rvx10_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_ILL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_ANDN = 4'b0110;
    localparam logic [3:0] ALU_ORN  = 4'b0111;
    localparam logic [3:0] ALU_XORN = 4'b1000;
    localparam logic [3:0] ALU_MIN  = 4'b1001;
    localparam logic [3:0] ALU_MAX  = 4'b1010;
    localparam logic [3:0] ALU_MINU = 4'b1011;
    localparam logic [3:0] ALU_MAXU = 4'b1100;
    localparam logic [3:0] ALU_ROL  = 4'b1101;
    localparam logic [3:0] ALU_ROR  = 4'b1110;
    localparam logic [3:0] ALU_ABS  = 4'b1111;

    localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
    localparam logic [6:0]  OPC_RVX10 = 7'b0001011;
    localparam logic [31:0] HALT_WORD = 32'h0000_0063;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TERM = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rvx10_instr_pack.sv
// Combinational packer: ALU control code plus register fields to a 32-bit
// R-type or RVX10 custom-0 instruction word, flagging the undefined code.
module rvx10_instr_pack
    import rvx10_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] word,
    output logic        illegal
);

    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
    logic [4:0] rs2_field;

    always_comb begin
        funct7    = 7'b0000000;
        funct3    = 3'b000;
        opcode    = OPC_RTYPE;
        rs2_field = rs2;
        illegal   = 1'b0;
        case (op)
            ALU_ADD:  funct3 = 3'b000;
            ALU_SUB:  begin funct3 = 3'b000; funct7 = 7'b0100000; end
            ALU_SLT:  funct3 = 3'b010;
            ALU_OR:   funct3 = 3'b110;
            ALU_AND:  funct3 = 3'b111;
            ALU_ANDN: begin opcode = OPC_RVX10; funct7 = 7'd0; funct3 = 3'b000; end
            ALU_ORN:  begin opcode = OPC_RVX10; funct7 = 7'd0; funct3 = 3'b001; end
            ALU_XORN: begin opcode = OPC_RVX10; funct7 = 7'd0; funct3 = 3'b010; end
            ALU_MIN:  begin opcode = OPC_RVX10; funct7 = 7'd1; funct3 = 3'b000; end
            ALU_MAX:  begin opcode = OPC_RVX10; funct7 = 7'd1; funct3 = 3'b001; end
            ALU_MINU: begin opcode = OPC_RVX10; funct7 = 7'd1; funct3 = 3'b010; end
            ALU_MAXU: begin opcode = OPC_RVX10; funct7 = 7'd1; funct3 = 3'b011; end
            ALU_ROL:  begin opcode = OPC_RVX10; funct7 = 7'd2; funct3 = 3'b000; end
            ALU_ROR:  begin opcode = OPC_RVX10; funct7 = 7'd2; funct3 = 3'b001; end
            // abs is unary; the rs2 slot is architecturally zero
            ALU_ABS:  begin opcode = OPC_RVX10; funct7 = 7'd3; funct3 = 3'b000; rs2_field = 5'd0; end
            default:  illegal = 1'b1;
        endcase
        word = {funct7, rs2_field, rs1, funct3, rd, opcode};
    end

endmodule

// File: rtl/rvx10_encoder.sv
// Program loader: turns a stream of ALU-op requests into instruction words
// written sequentially to IMEM, closing each session with a halt word.
module rvx10_encoder
    import rvx10_pkg::*;
#(
    parameter int                 IMEM_AW   = 6,
    parameter logic [IMEM_AW-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [4:0]         req_rd,
    input  logic [4:0]         req_rs1,
    input  logic [4:0]         req_rs2,
    input  logic               req_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err_illegal,
    output logic               err_overflow,
    output logic [IMEM_AW:0]   count
);

    localparam logic [IMEM_AW-1:0] LAST_SLOT = '1;
    localparam logic [IMEM_AW-1:0] PTR_ONE   = IMEM_AW'(1);
    localparam logic [IMEM_AW:0]   CNT_ONE   = (IMEM_AW + 1)'(1);

    state_t             state_reg;
    logic [IMEM_AW-1:0] ptr_reg;
    logic [IMEM_AW:0]   count_reg;
    logic               done_reg;
    logic               err_ill_reg;
    logic               err_ovf_reg;
    logic               halt_sent_reg;
    logic               we_reg;
    logic [IMEM_AW-1:0] addr_reg;
    logic [31:0]        wdata_reg;

    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        accept;

    rvx10_instr_pack u_pack (
        .op      (req_op),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // The final slot is kept free so the halt word always fits.
    assign req_ready = (state_reg == S_RUN) && (ptr_reg != LAST_SLOT);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= BASE_ADDR;
            count_reg     <= '0;
            done_reg      <= 1'b0;
            err_ill_reg   <= 1'b0;
            err_ovf_reg   <= 1'b0;
            halt_sent_reg <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
        end else begin
            we_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg   <= S_RUN;
                        ptr_reg     <= BASE_ADDR;
                        count_reg   <= '0;
                        done_reg    <= 1'b0;
                        err_ill_reg <= 1'b0;
                        err_ovf_reg <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (pack_illegal) begin
                            err_ill_reg <= 1'b1;
                        end else begin
                            we_reg    <= 1'b1;
                            addr_reg  <= ptr_reg;
                            wdata_reg <= pack_word;
                            ptr_reg   <= ptr_reg + PTR_ONE;
                            count_reg <= count_reg + CNT_ONE;
                        end
                        if (req_last) begin
                            state_reg <= S_TERM;
                        end
                    end else if (ptr_reg == LAST_SLOT) begin
                        err_ovf_reg <= 1'b1;
                        state_reg   <= S_TERM;
                    end
                end
                S_TERM: begin
                    // First cycle issues the halt write; busy stays up while it lands.
                    if (!halt_sent_reg) begin
                        we_reg        <= 1'b1;
                        addr_reg      <= ptr_reg;
                        wdata_reg     <= HALT_WORD;
                        count_reg     <= count_reg + CNT_ONE;
                        halt_sent_reg <= 1'b1;
                    end else begin
                        halt_sent_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= S_DONE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state_reg == S_RUN) || (state_reg == S_TERM);
    assign done         = done_reg;
    assign err_illegal  = err_ill_reg;
    assign err_overflow = err_ovf_reg;
    assign count        = count_reg;
    assign imem_we      = we_reg;
    assign imem_addr    = addr_reg;
    assign imem_wdata   = wdata_reg;

endmodule

// File: tb/tb_rvx10_encoder.sv
// Scoreboard bench for rvx10_encoder: a default-size instance (a) and a
// 4-word instance (b) for the overflow path share the request bus.
module tb_rvx10_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start_a, start_b, req_valid, req_last;
    logic [3:0] req_op;
    logic [4:0] req_rd, req_rs1, req_rs2;

    logic        a_ready, a_we, a_busy, a_done, a_ill, a_ovf;
    logic [5:0]  a_addr;
    logic [31:0] a_wdata;
    logic [6:0]  a_count;

    logic        b_ready, b_we, b_busy, b_done, b_ill, b_ovf;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;

    rvx10_encoder #(.IMEM_AW(6), .BASE_ADDR(6'd0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .req_valid(req_valid), .req_ready(a_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_last(req_last),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .busy(a_busy), .done(a_done), .err_illegal(a_ill), .err_overflow(a_ovf),
        .count(a_count)
    );

    rvx10_encoder #(.IMEM_AW(2), .BASE_ADDR(2'd0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .req_valid(req_valid), .req_ready(b_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_last(req_last),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .busy(b_busy), .done(b_done), .err_illegal(b_ill), .err_overflow(b_ovf),
        .count(b_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ptr = 0;
    logic [37:0] q_a[$];
    logic [33:0] q_b[$];

    // Reference encoding tables indexed by ALU control code.
    int f3_t[16]  = '{0, 0, 7, 6, 0, 2, 0, 1, 2, 0, 1, 2, 3, 0, 1, 0};
    int grp_t[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3};

    function automatic logic [31:0] tb_enc(logic [3:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        logic [6:0] f7, opc;
        logic [2:0] f3;
        logic [4:0] r2;
        f3 = 3'(f3_t[op]);
        r2 = (op == 4'd15) ? 5'd0 : rs2;
        if (op <= 4'd5) begin
            opc = 7'h33;
            f7  = (op == 4'd1) ? 7'h20 : 7'h00;
        end else begin
            opc = 7'h0B;
            f7  = 7'(grp_t[op]);
        end
        return {f7, r2, rs1, f3, rd, opc};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    always @(negedge clk) begin
        if (a_we) begin
            check("a_write_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                logic [37:0] e;
                e = q_a.pop_front();
                check("a_wr_addr", 32'(a_addr), 32'(e[37:32]));
                check("a_wr_data", a_wdata, e[31:0]);
            end
        end
        if (b_we) begin
            check("b_write_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                logic [33:0] e;
                e = q_b.pop_front();
                check("b_wr_addr", 32'(b_addr), 32'(e[33:32]));
                check("b_wr_data", b_wdata, e[31:0]);
            end
        end
    end

    task automatic push_exp(bit sel, int addr, logic [31:0] w);
        if (sel) q_b.push_back({2'(addr), w});
        else     q_a.push_back({6'(addr), w});
    endtask

    task automatic begin_session(bit sel);
        @(posedge clk); #1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        exp_ptr = 0;
    endtask

    // Present one request; returns whether it was accepted and the stall cycles seen.
    task automatic send(bit sel, logic [3:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                        bit last, logic [31:0] exp_word, output bit ok, output int waits);
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_last = last;
        req_valid = 1'b1;
        ok = 1'b0;
        waits = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (sel ? b_ready : a_ready) begin
                ok = 1'b1;
                if (op != 4'b0100) begin
                    push_exp(sel, exp_ptr, exp_word);
                    exp_ptr++;
                end
                if (last) push_exp(sel, exp_ptr, 32'h0000_0063);
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(bit sel, string tag);
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel ? b_done : a_done) break;
        end
        check(tag, 32'(sel ? b_done : a_done), 1);
    endtask

    initial begin
        bit ok;
        int w, stalls;
        logic [4:0] r1, r2, r3;

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; req_valid = 1'b0; req_last = 1'b0;
        req_op = 4'd0; req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we",    32'(a_we), 0);
        check("rst_addr",  32'(a_addr), 0);
        check("rst_wdata", a_wdata, 0);
        check("rst_busy",  32'(a_busy), 0);
        check("rst_done",  32'(a_done), 0);
        check("rst_ready", 32'(a_ready), 0);
        check("rst_count", 32'(a_count), 0);
        check("rst_errs",  32'({a_ill, a_ovf}), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic encode plus done/busy timing after the last accept.
        begin_session(0);
        check("t1_busy_run", 32'(a_busy), 1);
        send(0, 4'b0000, 5'd3, 5'd1, 5'd2, 1, 32'h002081B3, ok, w);
        check("t1_accept", 32'(ok), 1);
        @(negedge clk);
        check("t1_done_n1", 32'(a_done), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_done_n2m", 32'(a_done), 0);
        check("t1_busy_n2m", 32'(a_busy), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_done_n2", 32'(a_done), 1);
        check("t1_busy_n2", 32'(a_busy), 0);
        check("t1_count", 32'(a_count), 2);
        req_valid = 1'b0;

        // Back-to-back stream at one word per cycle.
        begin_session(0);
        stalls = 0;
        send(0, 4'b0001, 5'd3, 5'd1, 5'd2, 0, 32'h402081B3, ok, w); stalls += w;
        send(0, 4'b1001, 5'd5, 5'd6, 5'd7, 0, 32'h0273028B, ok, w); stalls += w;
        send(0, 4'b1101, 5'd1, 5'd2, 5'd3, 1, 32'h0431008B, ok, w); stalls += w;
        check("t2_stalls", 32'(stalls), 0);
        wait_done(0, "t2_done");
        check("t2_count", 32'(a_count), 4);

        // abs forces the rs2 field to zero.
        begin_session(0);
        send(0, 4'b1111, 5'd10, 5'd11, 5'd9, 1, 32'h0605850B, ok, w);
        wait_done(0, "t3_done");
        check("t3_count", 32'(a_count), 2);

        // Sweep every legal code with random register fields.
        begin_session(0);
        for (int op = 0; op < 16; op++) begin
            if (op == 4) continue;
            r1 = 5'($urandom_range(0, 31));
            r2 = 5'($urandom_range(0, 31));
            r3 = 5'($urandom_range(0, 31));
            send(0, 4'(op), r1, r2, r3, op == 15, tb_enc(4'(op), r1, r2, r3), ok, w);
        end
        wait_done(0, "sweep_done");
        check("sweep_count", 32'(a_count), 16);
        check("sweep_ill", 32'(a_ill), 0);

        // Illegal code between two adds: accepted, not written.
        begin_session(0);
        send(0, 4'b0000, 5'd1, 5'd2, 5'd3, 0, tb_enc(4'd0, 5'd1, 5'd2, 5'd3), ok, w);
        send(0, 4'b0100, 5'd7, 5'd7, 5'd7, 0, 32'h0, ok, w);
        check("t4_ill_accept", 32'(ok), 1);
        send(0, 4'b0000, 5'd4, 5'd5, 5'd6, 1, tb_enc(4'd0, 5'd4, 5'd5, 5'd6), ok, w);
        wait_done(0, "t4_done");
        check("t4_ill", 32'(a_ill), 1);
        check("t4_count", 32'(a_count), 3);

        // Illegal code carrying last still terminates the session.
        begin_session(0);
        check("t4b_ill_cleared", 32'(a_ill), 0);
        send(0, 4'b0000, 5'd8, 5'd9, 5'd10, 0, tb_enc(4'd0, 5'd8, 5'd9, 5'd10), ok, w);
        send(0, 4'b0100, 5'd1, 5'd1, 5'd1, 1, 32'h0, ok, w);
        wait_done(0, "t4b_done");
        check("t4b_count", 32'(a_count), 2);

        // Overflow on the 4-word instance.
        begin_session(1);
        for (int i = 0; i < 3; i++) begin
            send(1, 4'b0000, 5'(i + 1), 5'd2, 5'd3, 0, tb_enc(4'd0, 5'(i + 1), 5'd2, 5'd3), ok, w);
            check("t5_accept", 32'(ok), 1);
        end
        push_exp(1, 3, 32'h0000_0063);
        @(negedge clk);
        check("t5_ready_full", 32'(b_ready), 0);
        for (int i = 0; i < 2; i++) begin
            send(1, 4'b0000, 5'd9, 5'd9, 5'd9, 0, 32'h0, ok, w);
            check("t5_reject", 32'(ok), 0);
        end
        wait_done(1, "t5_done");
        check("t5_ovf", 32'(b_ovf), 1);
        check("t5_count", 32'(b_count), 4);

        // Reset mid-session after two writes, then restart from BASE_ADDR.
        begin_session(0);
        send(0, 4'b0000, 5'd1, 5'd1, 5'd1, 0, tb_enc(4'd0, 5'd1, 5'd1, 5'd1), ok, w);
        send(0, 4'b0010, 5'd2, 5'd2, 5'd2, 0, tb_enc(4'd2, 5'd2, 5'd2, 5'd2), ok, w);
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_we",    32'(a_we), 0);
        check("t6_busy",  32'(a_busy), 0);
        check("t6_count", 32'(a_count), 0);
        check("t6_ready", 32'(a_ready), 0);
        begin_session(0);
        send(0, 4'b0011, 5'd4, 5'd5, 5'd6, 1, tb_enc(4'd3, 5'd4, 5'd5, 5'd6), ok, w);
        wait_done(0, "t6_done");
        check("t6_count2", 32'(a_count), 2);

        repeat (2) @(negedge clk);
        check("q_a_drained", 32'(q_a.size()), 0);
        check("q_b_drained", 32'(q_b.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
